pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage 19-bit pipeline (IF, ID, EX, MEM, WB). It watches the decode stage (register sources, conditional branch, redirect) against the downstream stage destinations and flag writers. From these it drives the pipeline-register enables, bubble/squash controls, and the registered operand-forwarding selects. It is the single owner of all stall, flush and freeze decisions; the datapath stages only obey its enables.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_fwd_unit.sv | 63 ++++++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants for the pipeline hazard controller
package hazard_pkg;

    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WBREG = 2'b11;

endpackage

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - per-operand forwarding priority compare and select registers
module hazard_fwd_unit #(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  ex_reg_write,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  load_en,
    input  logic                  bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
);
    import hazard_pkg::*;

    logic [1:0][REG_ADDR_W-1:0] src;
    logic [1:0]                 src_used;
    logic [1:0][1:0]            pick;
    logic [1:0][1:0]            sel_d;
    logic [1:0][1:0]            sel_q;

    assign src      = {id_rs2, id_rs1};
    assign src_used = {id_use_rs2, id_use_rs1};

    // Checked oldest-first so the youngest matching producer overwrites.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pick[i] = FWD_RF;
            if (src_used[i]) begin
                if (wb_reg_write && (wb_dest == src[i]))   pick[i] = FWD_WBREG;
                if (mem_reg_write && (mem_dest == src[i])) pick[i] = FWD_MEMWB;
                if (ex_reg_write && (ex_dest == src[i]))   pick[i] = FWD_EXMEM;
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (load_en) begin
            sel_d = bubble ? {FWD_RF, FWD_RF} : pick;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign fwd_a_sel = sel_q[0];
    assign fwd_b_sel = sel_q[1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze controller; HAZARD_PERF_CNT_EN adds stall/flush counters
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_cond_branch,
    input  logic                  id_redirect,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  ex_reg_write,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_sets_flags,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [1:0]            hz_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);
    import hazard_pkg::*;

    hz_state_e state_q, state_d;
    logic      load_use;
    logic      flag_hz;
    logic      do_stall;

    assign load_use = ex_mem_read && ex_reg_write &&
                      ((id_use_rs1 && (ex_dest == id_rs1)) ||
                       (id_use_rs2 && (ex_dest == id_rs2)));
    assign flag_hz  = id_cond_branch && ex_sets_flags;
    // Leaving FREEZE behaves like RUN; only STALL is exempt since EX then holds a bubble.
    assign do_stall = !mem_busy && (state_q != STALL) && (load_use || flag_hz);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = RUN;
        if (mem_busy) begin
            state_d = FREEZE;
        end else if (do_stall) begin
            state_d = STALL;
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (do_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_redirect) begin
            ifid_flush = 1'b1;
        end
    end

    assign hz_state = state_q;

    hazard_fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_dest       (ex_dest),
        .mem_dest      (mem_dest),
        .wb_dest       (wb_dest),
        .ex_reg_write  (ex_reg_write),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .load_en       (idex_en),
        .bubble        (idex_flush),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (idex_flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ifid_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks against a reference model
module tb_pipeline_hazard_ctrl;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] id_rs1, id_rs2, ex_dest, mem_dest, wb_dest;
    logic          id_use_rs1, id_use_rs2, id_cond_branch, id_redirect;
    logic          ex_reg_write, mem_reg_write, wb_reg_write;
    logic          ex_mem_read, ex_sets_flags, mem_busy;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [1:0]    fwd_a_sel, fwd_b_sel, hz_state;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            m_state  = 0;
    int            m_fa     = 0;
    int            m_fb     = 0;
    logic [6:0]    last_ctl;
    logic [1:0]    last_state;

`ifdef HAZARD_PERF_CNT_EN
    localparam int CW = 6;
    logic [CW-1:0] stall_cnt, flush_cnt;
    int            m_stall = 0;
    int            m_flush = 0;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (AW)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .CNT_W      (CW)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_cond_branch (id_cond_branch),
        .id_redirect    (id_redirect),
        .ex_dest        (ex_dest),
        .mem_dest       (mem_dest),
        .wb_dest        (wb_dest),
        .ex_reg_write   (ex_reg_write),
        .mem_reg_write  (mem_reg_write),
        .wb_reg_write   (wb_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_sets_flags  (ex_sets_flags),
        .mem_busy       (mem_busy),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .hz_state       (hz_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Forwarding code is 1 + age rank of the youngest matching writer (EX=1, MEM=2, WB=3).
    function automatic int pick(input int src, input bit used);
        int dst[3];
        bit wr[3];
        dst = '{int'(ex_dest), int'(mem_dest), int'(wb_dest)};
        wr  = '{ex_reg_write, mem_reg_write, wb_reg_write};
        if (!used) return 0;
        for (int i = 0; i < 3; i++) begin
            if (wr[i] && dst[i] == src) return i + 1;
        end
        return 0;
    endfunction

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_cond_branch = 0; id_redirect = 0;
        ex_dest = 0; mem_dest = 0; wb_dest = 0;
        ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
        ex_mem_read = 0; ex_sets_flags = 0; mem_busy = 0;
    endtask

    task automatic model_reset();
        m_state = 0; m_fa = 0; m_fb = 0;
`ifdef HAZARD_PERF_CNT_EN
        m_stall = 0; m_flush = 0;
`endif
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        bit         hz;
        logic [6:0] ectl;
        int         na, nb;
        #1;
        hz = (m_state != 1) &&
             ((ex_mem_read && ex_reg_write &&
               ((id_use_rs1 && ex_dest == id_rs1) || (id_use_rs2 && ex_dest == id_rs2))) ||
              (id_cond_branch && ex_sets_flags));
        if (mem_busy)         ectl = 7'b0000000;
        else if (hz)          ectl = 7'b0011101;
        else if (id_redirect) ectl = 7'b1111110;
        else                  ectl = 7'b1111100;
        last_ctl   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
        last_state = hz_state;
        check_eq("ctl", 32'(last_ctl), 32'(ectl));
        check_eq("hz_state", 32'(hz_state), 32'(m_state));
        check_eq("fwd_a", 32'(fwd_a_sel), 32'(m_fa));
        check_eq("fwd_b", 32'(fwd_b_sel), 32'(m_fb));
`ifdef HAZARD_PERF_CNT_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
        na = pick(int'(id_rs1), id_use_rs1);
        nb = pick(int'(id_rs2), id_use_rs2);
        @(posedge clk);
        m_state = mem_busy ? 2 : (hz ? 1 : 0);
        if (ectl[4]) begin
            m_fa = ectl[0] ? 0 : na;
            m_fb = ectl[0] ? 0 : nb;
        end
`ifdef HAZARD_PERF_CNT_EN
        if (ectl[0] && m_stall < (1 << CW) - 1) m_stall++;
        if (ectl[1] && m_flush < (1 << CW) - 1) m_flush++;
`endif
        @(negedge clk);
    endtask

    task automatic set_load_use_r3();
        ex_mem_read = 1; ex_reg_write = 1; ex_dest = 3;
        id_rs1 = 3; id_use_rs1 = 1;
    endtask

    task automatic load_moves_to_mem();
        ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0;
        mem_dest = 3; mem_reg_write = 1;
    endtask

    initial begin
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;

        // reset state
        step();
        check_eq("rst_ctl", 32'(last_ctl), 32'h7C);
        check_eq("rst_state", 32'(last_state), 0);

        // load-use on rs1
        set_load_use_r3();
        step();
        check_eq("lu_ctl", 32'(last_ctl), 32'h1D);
        load_moves_to_mem();
        step();
        check_eq("lu_stall_state", 32'(last_state), 1);
        check_eq("lu_fwd_a", 32'(fwd_a_sel), 2);
        set_idle();
        step();

        // ALU forward from EX, EX wins over MEM
        ex_reg_write = 1; ex_dest = 5; id_rs2 = 5; id_use_rs2 = 1;
        step();
        check_eq("alu_fwd_b", 32'(fwd_b_sel), 1);
        mem_dest = 5; mem_reg_write = 1; wb_dest = 5; wb_reg_write = 1;
        step();
        check_eq("alu_fwd_b_young", 32'(fwd_b_sel), 1);
        set_idle();
        wb_dest = 2; wb_reg_write = 1; id_rs1 = 2; id_use_rs1 = 1;
        step();
        check_eq("wb_fwd_a", 32'(fwd_a_sel), 3);
        set_idle();

        // flag hazard then redirect
        id_cond_branch = 1; ex_sets_flags = 1;
        step();
        check_eq("flag_ctl", 32'(last_ctl), 32'h1D);
        ex_sets_flags = 0; id_redirect = 1;
        step();
        check_eq("redir_ctl", 32'(last_ctl), 32'h7E);
        set_idle();

        // freeze over a load-use, then the stall, then RUN
        set_load_use_r3();
        mem_busy = 1;
        id_redirect = 1;
        repeat (3) begin
            step();
            check_eq("frz_ctl", 32'(last_ctl), 0);
        end
        mem_busy = 0;
        step();
        check_eq("post_frz_ctl", 32'(last_ctl), 32'h1D);
        load_moves_to_mem();
        step();
        check_eq("post_frz_state", 32'(last_state), 1);
        check_eq("post_stall_redir", 32'(last_ctl), 32'h7E);
        set_idle();
        step();
        check_eq("back_run", 32'(last_state), 0);

        // asynchronous reset in the middle of STALL
        set_load_use_r3();
        step();
        set_idle();
        #2;
        rst = 0;
        #1;
        check_eq("async_rst_state", 32'(hz_state), 0);
        model_reset();
        @(negedge clk);
        rst = 1;
        step();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            id_rs1 = AW'($urandom_range(0, 3));
            id_rs2 = AW'($urandom_range(0, 3));
            ex_dest = AW'($urandom_range(0, 3));
            mem_dest = AW'($urandom_range(0, 3));
            wb_dest = AW'($urandom_range(0, 7));
            id_use_rs1 = $urandom_range(0, 3) != 0;
            id_use_rs2 = $urandom_range(0, 1) != 0;
            ex_reg_write = $urandom_range(0, 1) != 0;
            mem_reg_write = $urandom_range(0, 1) != 0;
            wb_reg_write = $urandom_range(0, 1) != 0;
            ex_mem_read = $urandom_range(0, 2) == 0;
            id_cond_branch = $urandom_range(0, 3) == 0;
            ex_sets_flags = $urandom_range(0, 2) == 0;
            id_redirect = $urandom_range(0, 3) == 0;
            mem_busy = $urandom_range(0, 5) == 0;
            step();
        end
        set_idle();
        step();

`ifdef HAZARD_PERF_CNT_EN
        // forced stalls past saturation
        set_load_use_r3();
        repeat (2 * ((1 << CW) + 2)) step();
        set_idle();
        step();
        check_eq("stall_cnt_sat", 32'(stall_cnt), 32'((1 << CW) - 1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
